// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: XLEN, M-extension funct3 encodings and the MDU state enum.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} mdu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// Shared 65-bit accumulator: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
module mdu_iter #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           mode,     // 0: multiply, 1: divide
    input  logic [W-1:0]   init_lo,  // multiplier or dividend magnitude
    input  logic [W-1:0]   oper,     // multiplicand or divisor magnitude
    output logic [2*W-1:0] res_nxt   // {hi, lo} after the current step
);
    logic [2*W:0] acc, acc_nxt;
    logic [W:0]   sum, rem_s, diff;
    logic         ge;

    always_comb begin
        sum     = acc[2*W:W] + {1'b0, oper};
        rem_s   = {acc[2*W-1:W], acc[W-1]};
        diff    = rem_s - {1'b0, oper};
        ge      = rem_s >= {1'b0, oper};
        acc_nxt = acc;
        if (!mode) begin
            // Add when the multiplier LSB is set, then shift the whole pair right.
            acc_nxt = acc[0] ? {1'b0, sum, acc[W-1:1]} : {1'b0, acc[2*W:1]};
        end else begin
            // Remainder shifts in the next dividend bit; quotient bit enters at the bottom.
            acc_nxt = {(ge ? diff : rem_s), acc[W-2:0], ge};
        end
    end

    assign res_nxt = acc_nxt[2*W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (load)
            acc <= {{(W+1){1'b0}}, init_lo};
        else if (step)
            acc <= acc_nxt;
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling and special cases around mdu_iter.
module mul_div_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t         state_q, state_d;
    logic [5:0]         cnt;
    logic [2:0]         f3_q;
    logic [4:0]         rd_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opb_q;

    logic               is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div0, ovf, special;
    logic [WIDTH-1:0]   sp_res;
    logic               load, step, fin;
    logic [2*WIDTH-1:0] res_nxt, sprod;
    logic [WIDTH-1:0]   quo, rem, fin_res;

    // Operand decode, magnitudes and special-case detection at the start edge.
    always_comb begin
        is_div  = funct3[2];
        a_sgn   = is_div ? ~funct3[0] : (funct3 == MULH_F3 || funct3 == MULHSU_F3);
        b_sgn   = is_div ? ~funct3[0] : (funct3 == MULH_F3);
        a_neg   = a_sgn & op_a[WIDTH-1];
        b_neg   = b_sgn & op_b[WIDTH-1];
        mag_a   = a_neg ? -op_a : op_a;
        mag_b   = b_neg ? -op_b : op_b;
        neg_in  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div0    = is_div && (op_b == '0);
        ovf     = is_div && !funct3[0] && (op_a == SMIN) && (op_b == '1);
        special = div0 || ovf;
        if (div0)
            sp_res = funct3[1] ? op_a : '1;
        else
            sp_res = funct3[1] ? '0 : SMIN;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load    = !special;
                state_d = special ? FINISH : CALC;
            end
            CALC: begin
                step = 1'b1;
                if (cnt == 6'(WIDTH-1)) begin
                    fin     = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FINISH);

    mdu_iter #(.W(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .mode    (f3_q[2]),
        .init_lo (mag_a),
        .oper    (opb_q),
        .res_nxt (res_nxt)
    );

    // Sign correction on the value produced by the final iteration.
    always_comb begin
        sprod = neg_q ? -res_nxt : res_nxt;
        quo   = neg_q ? -res_nxt[WIDTH-1:0] : res_nxt[WIDTH-1:0];
        rem   = neg_q ? -res_nxt[2*WIDTH-1:WIDTH] : res_nxt[2*WIDTH-1:WIDTH];
        if (!f3_q[2])
            fin_res = (f3_q == MUL_F3) ? sprod[WIDTH-1:0] : sprod[2*WIDTH-1:WIDTH];
        else
            fin_res = f3_q[1] ? rem : quo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                cnt   <= '0;
                f3_q  <= funct3;
                rd_q  <= rd_in;
                neg_q <= neg_in;
                opb_q <= mag_b;
                if (special) begin
                    result <= sp_res;
                    rd_out <= rd_in;
                end
            end else if (step) begin
                cnt <= cnt + 6'd1;
            end
            if (fin) begin
                result <= fin_res;
                rd_out <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, ignored starts, back-to-back and reset.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    // Issue one op, then watch for done (bounded). lat counts falling edges after the start edge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; rd_in = 5'd31; funct3 = 3'b000;
        lat = -1; busy_ok = 1'b1; res = '0; rdo = '0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k; res = result; rdo = rd_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 32'h0 || rd_out !== 5'h0) begin bad++; $display("FAIL reset_data result=%h rd=%0d want 0 0", result, rd_out); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        logic [2:0]  f  [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
        logic [31:0] a  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], 5'(i + 5), r, d, lat, bok);
            total++; if (r !== ex[i]) begin bad++; $display("FAIL mul_res[%0d] got=%h want=%h", i, r, ex[i]); end
            total++; if (d !== 5'(i + 5)) begin bad++; $display("FAIL mul_rd[%0d] got=%0d want=%0d", i, d, i + 5); end
            total++; if (lat != 32 || !bok) begin bad++; $display("FAIL mul_lat[%0d] lat=%0d busy_ok=%0b want 32 1", i, lat, bok); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul_pulse done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        logic [2:0]  f  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
        logic [31:0] b  [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
        logic [31:0] ex [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], 5'(i + 12), r, d, lat, bok);
            total++; if (r !== ex[i]) begin bad++; $display("FAIL div_res[%0d] got=%h want=%h", i, r, ex[i]); end
            total++; if (d !== 5'(i + 12) || lat != 32) begin bad++; $display("FAIL div_rd_lat[%0d] rd=%0d lat=%0d want %0d 32", i, d, lat, i + 12); end
        end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [4:0] d; int lat; bit bok;
        logic [2:0]  f  [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] a  [4] = '{32'd100, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], 5'(i + 20), r, d, lat, bok);
            total++; if (r !== ex[i]) begin bad++; $display("FAIL spec_res[%0d] got=%h want=%h", i, r, ex[i]); end
            total++; if (d !== 5'(i + 20) || lat != 0) begin bad++; $display("FAIL spec_rd_lat[%0d] rd=%0d lat=%0d want %0d 0", i, d, lat, i + 20); end
            @(negedge clk);
            total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL spec_idle[%0d] busy=%b done=%b want 0 0", i, busy, done); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int lat = -1; logic [31:0] r = '0; logic [4:0] d = '0;
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin ndone++; if (lat < 0) begin lat = k; r = result; d = rd_out; end end
            if (k == 5) begin funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1; start = 1'b1; end
            if (k == 6) start = 1'b0;
            @(negedge clk);
        end
        total++; if (r !== 32'd14 || d !== 5'd9) begin bad++; $display("FAIL ignore_res got=%h rd=%0d want 0000000e 9", r, d); end
        total++; if (ndone != 1 || lat != 32) begin bad++; $display("FAIL ignore_done n=%0d lat=%0d want 1 32", ndone, lat); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0; int l0 = -1, l1 = -1; logic [31:0] r0 = '0, r1 = '0;
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            if (done) begin
                ndone++;
                if (l0 < 0) begin l0 = k; r0 = result; end
                else if (l1 < 0) begin l1 = k; r1 = result; end
            end
            if (k == 33) begin funct3 = 3'b111; rd_in = 5'd4; end
            if (k == 34) start = 1'b0;
            @(negedge clk);
        end
        total++; if (ndone != 2) begin bad++; $display("FAIL b2b_count got=%0d want 2", ndone); end
        total++; if (l0 != 32 || l1 != 66) begin bad++; $display("FAIL b2b_lat got=%0d,%0d want 32,66", l0, l1); end
        total++; if (r0 !== 32'd14 || r1 !== 32'd2) begin bad++; $display("FAIL b2b_res got=%h,%h want 0000000e,00000002", r0, r1); end
        total++; if (rd_out !== 5'd4) begin bad++; $display("FAIL b2b_rd got=%0d want 4", rd_out); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0; logic [31:0] r; logic [4:0] d; int lat; bit bok;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'h1234_5678; op_b = 32'd2; rd_in = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 32'h0 || rd_out !== 5'h0) begin bad++; $display("FAIL rstmid_data result=%h rd=%0d want 0 0", result, rd_out); end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_nodone got=%0d want 0", ndone); end
        run_op(3'b000, 32'd3, 32'd4, 5'd2, r, d, lat, bok);
        total++; if (r !== 32'd12 || d !== 5'd2 || lat != 32) begin bad++; $display("FAIL rstmid_after res=%h rd=%0d lat=%0d want 0000000c 2 32", r, d, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit for the RISC-V core. It sits directly downstream of `Register_File` and takes its operands from `RD1`/`RD2`. It returns its result, destination index and a one-cycle completion strobe to the write-back path, which drives `WD3`/`A3`/`WE3`. All eight M-extension operations share one 32-iteration shift datapath, controlled by a small FSM with a start/busy/done handshake.

## Interface
- `WIDTH`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: operation request; sampled only in IDLE.
- `funct3`  in  3: selects the operation. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32: rs1 value (from `RD1`).
- `op_b`  in  32: rs2 value (from `RD2`).
- `rd_in`  in  5: destination register index; latched with the operands.
- `busy`  out  1: high in CALC and FINISH.
- `done`  out  1: single-cycle pulse; `result`/`rd_out` are valid while it is high.
- `result`  out  32: operation result; held until the next `done`.
- `rd_out`  out  5: latched `rd_in`; x0 is passed through unchanged, and the register file discards it.

## Operation
- FSM states: IDLE, CALC, FINISH.
- **IDLE, `start`=1:**
  - Latch `funct3`, `rd_in`, and operand magnitudes.
  - Clear the 6-bit iteration counter.
  - Go to CALC.
- **IDLE, `start`=1, special case detected:** go straight to FINISH, loading `result` directly.
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result `op_a`.
  - Signed overflow (DIV/REM with `op_a`=0x80000000, `op_b`=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- **CALC:** one iteration per cycle for 32 cycles (counter 0..31). At count 31, apply sign correction, load `result`, and go to FINISH.
- **FINISH:** `done`=1 for exactly one cycle, then return to IDLE.
- **Multiply:** 64-bit shift-add on magnitudes.
  - Signedness: MULH treats both operands as signed; MULHSU treats `op_a` as signed and `op_b` as unsigned; MULHU and MUL are unsigned. The low word of MUL is sign-independent.
  - If signed-ness applies, negate the 64-bit product when the operand signs differ.
  - MUL returns product[31:0]; all MULH* variants return product[63:32].
- **Divide:** restoring division, one quotient bit per cycle, on magnitudes.
  - Signed quotient is negative when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - The quotient truncates toward zero.
- **`start` outside IDLE** (CALC or FINISH): ignored. No queuing.
- **Reset** (asserted at any time, including mid-operation) clears immediately:
  - state → IDLE, counter → 0;
  - `busy`, `done` → 0;
  - `result` → 0, `rd_out` → 0;
  - any in-flight operation is discarded.

## Timing
- Operands are sampled on the start edge E0. The upstream stage must hold the register-file addresses only through E0.
- **Normal latency:** CALC occupies the cycles after E0 through E32. `result` loads at E32, and `done` is high during the cycle E32→E33. `busy` is high from E0 to E33.
- **Special-case latency:** `result` loads at E0, and `done` is high during E0→E1. `busy` is high for that cycle only.
- **Throughput:** the earliest next accepted start is the IDLE cycle after FINISH, i.e. edge E34 for the normal path and E2 for the special path.
- `result` and `rd_out` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants MUL_F3 … REMU_F3;
  - state enum IDLE/CALC/FINISH;
  - the value `XLEN=32`.
- Sub-module `mdu_iter` holds the 65-bit accumulator/shift datapath: one add-or-subtract step per cycle plus a mode bit. The FSM, sign handling and special-case detection stay in the top level.

## Test plan
- MUL, `op_a`=7, `op_b`=0xFFFFFFFD, `rd_in`=5 → one `done` pulse, `result`=0xFFFFFFEB, `rd_out`=5. `busy` stays high across all 32 CALC cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH on the same operands → 0x00000000; MULHSU on the same operands → 0xFFFFFFFF.
- DIV 0xFFFFFFEC/3 → 0xFFFFFFFA; REM on the same operands → 0xFFFFFFFE; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 100/0 → 0xFFFFFFFF with `done` high in the cycle after the start edge. REM 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- `start` pulsed again at iteration 5 with different operands → ignored; the original result is returned. Back-to-back starts yield exactly one `done` per accepted operation.
- `rst` pulled low at iteration 10 → `busy`, `done`, `result` and `rd_out` go to 0 immediately, with no later `done`. After release, MUL 3×4 → 12.
